anc_tap_seq: RTL and testbench

- Upstream feeder for the ANC inner-product accumulator.
- Holds the reference-signal delay line (TAP_NUM most recent samples) and the filter weight memory.
- On each new input sample it streams TAP_NUM (sample, weight) pairs, one per clock, tagged with a 7-bit frame index 1..TAP_NUM.
- Then issues a one-cycle frame TAP_NUM+1 marker, during which the accumulator's result is valid.

---
 rtl/anc_tap_seq_if.sv | 27 ++
 rtl/anc_tap_seq.sv | 130 +++++++++++++
 tb/tb_anc_tap_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/anc_tap_seq_if.sv
// Sample/weight input and tap-stream output bundle for anc_tap_seq.
// master drives samples and weights; slave is the sequencer.
interface anc_tap_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int W_WIDTH    = 24
);
  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic                         w_we;
  logic [6:0]                   w_addr;
  logic signed [W_WIDTH-1:0]    w_data;
  logic [6:0]                   frame;
  logic signed [DATA_WIDTH-1:0] in_1;
  logic signed [W_WIDTH-1:0]    in_2;
  logic                         busy;
  logic                         sample_drop;

  modport master (
    output sample_valid, sample_in, w_we, w_addr, w_data,
    input  frame, in_1, in_2, busy, sample_drop
  );

  modport slave (
    input  sample_valid, sample_in, w_we, w_addr, w_data,
    output frame, in_1, in_2, busy, sample_drop
  );
endinterface

// File: rtl/anc_tap_seq.sv
// ANC tap sequencer: delay line + weight memory streamed as (sample, weight) pairs per frame.
// Optional ANC_TAP_SEQ_FLUSH_EN adds a flush input that clears the delay line and aborts a run.
module anc_tap_seq #(
  parameter int TAP_NUM    = 126,
  parameter int DATA_WIDTH = 16,
  parameter int W_WIDTH    = 24
) (
  input logic clk,
  input logic rst,
`ifdef ANC_TAP_SEQ_FLUSH_EN
  input logic flush,
`endif
  anc_tap_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] LAST    = 7'(TAP_NUM);
  localparam logic [6:0] PTR_MAX = 7'(TAP_NUM - 1);

  state_t state_q, state_d;
  logic [6:0] frame_q, frame_d;
  logic [6:0] wr_q, wr_d, rd_q, rd_d;
  logic signed [DATA_WIDTH-1:0] in1_q, in1_d;
  logic signed [W_WIDTH-1:0]    in2_q, in2_d;
  logic busy_q, drop_q, drop_d;
  logic dly_we, dly_clr, flush_hit;

  logic signed [DATA_WIDTH-1:0] dly_q [TAP_NUM];
  logic signed [W_WIDTH-1:0]    w_q   [TAP_NUM];

  function automatic logic [6:0] ptr_inc(input logic [6:0] p);
    return (p == PTR_MAX) ? '0 : p + 7'd1;
  endfunction

  function automatic logic [6:0] ptr_dec(input logic [6:0] p);
    return (p == '0) ? PTR_MAX : p - 7'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    in1_d     = '0;
    in2_d     = '0;
    drop_d    = 1'b0;
    dly_we    = 1'b0;
    dly_clr   = 1'b0;
    flush_hit = 1'b0;
`ifdef ANC_TAP_SEQ_FLUSH_EN
    flush_hit = flush;
`endif
    if (flush_hit) begin
      state_d = IDLE;
      frame_d = '0;
      wr_d    = '0;
      dly_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            // Frame 1 takes the incoming sample directly; rd_q then starts one slot older.
            dly_we  = 1'b1;
            wr_d    = ptr_inc(wr_q);
            rd_d    = ptr_dec(wr_q);
            frame_d = 7'd1;
            in1_d   = bus.sample_in;
            in2_d   = w_q[0];
            state_d = RUN;
          end
        end
        RUN: begin
          drop_d  = bus.sample_valid;
          frame_d = frame_q + 7'd1;
          if (frame_q == LAST) begin
            state_d = DONE;
          end else begin
            in1_d = dly_q[rd_q];
            in2_d = w_q[frame_q];
            rd_d  = ptr_dec(rd_q);
          end
        end
        DONE: begin
          drop_d  = bus.sample_valid;
          frame_d = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      dly_q   <= '{default: '0};
      w_q     <= '{default: '0};
    end else begin
      frame_q <= frame_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      busy_q  <= (frame_d != '0);
      drop_q  <= drop_d;
      if (dly_clr)     dly_q        <= '{default: '0};
      else if (dly_we) dly_q[wr_q]  <= bus.sample_in;
      if (bus.w_we && (bus.w_addr < LAST)) w_q[bus.w_addr] <= bus.w_data;
    end
  end

  assign bus.frame       = frame_q;
  assign bus.in_1        = in1_q;
  assign bus.in_2        = in2_q;
  assign bus.busy        = busy_q;
  assign bus.sample_drop = drop_q;

endmodule

// File: tb/tb_anc_tap_seq.sv
// Self-checking bench for anc_tap_seq: history/weight-array model compared every cycle
// plus directed literal checks; flush scenarios run when ANC_TAP_SEQ_FLUSH_EN is defined.
module tb_anc_tap_seq;
  localparam int T = 126;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef ANC_TAP_SEQ_FLUSH_EN
  logic flush = 1'b0;
`endif

  anc_tap_seq_if #(.DATA_WIDTH(16), .W_WIDTH(24)) bus ();

  anc_tap_seq #(.TAP_NUM(T), .DATA_WIDTH(16), .W_WIDTH(24)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef ANC_TAP_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: newest-first history of accepted samples plus a plain weight array.
  int                 m_frame;
  logic signed [15:0] m_in1;
  logic signed [23:0] m_in2;
  bit                 m_drop;
  logic signed [15:0] hist[$];
  logic signed [23:0] mw[T];

  function automatic logic signed [15:0] hist_at(input int i);
    return (i < hist.size()) ? hist[i] : 16'sd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_frame = 0; m_in1 = '0; m_in2 = '0; m_drop = 1'b0;
      hist.delete();
      mw = '{default: '0};
    end else begin
      bit fl;
      int nf;
      fl = 1'b0;
`ifdef ANC_TAP_SEQ_FLUSH_EN
      fl = flush;
`endif
      m_drop = 1'b0;
      if (fl) begin
        hist.delete();
        m_frame = 0; m_in1 = '0; m_in2 = '0;
      end else if (m_frame == 0) begin
        m_in1 = '0; m_in2 = '0;
        if (bus.sample_valid) begin
          hist.push_front(bus.sample_in);
          if (hist.size() > T) void'(hist.pop_back());
          m_frame = 1; m_in1 = hist[0]; m_in2 = mw[0];
        end
      end else begin
        m_drop = bus.sample_valid;
        nf = m_frame + 1;
        if (nf <= T) begin
          m_in1 = hist_at(nf - 1); m_in2 = mw[nf - 1];
        end else begin
          m_in1 = '0; m_in2 = '0;
        end
        m_frame = (nf == T + 2) ? 0 : nf;
      end
      if (bus.w_we && bus.w_addr < T) mw[bus.w_addr] = bus.w_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (bus.frame !== 7'(m_frame) || bus.in_1 !== m_in1 || bus.in_2 !== m_in2 ||
          bus.busy !== (m_frame != 0) || bus.sample_drop !== m_drop) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t frame %0d req %0d, in_1 %0d req %0d, in_2 %0d req %0d, busy %0b req %0b, drop %0b req %0b",
                 $time, bus.frame, m_frame, bus.in_1, m_in1, bus.in_2, m_in2,
                 bus.busy, (m_frame != 0), bus.sample_drop, m_drop);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic signed [15:0] s);
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc;
    bit zero_ok;
    bus.sample_valid = 1'b0; bus.sample_in = '0;
    bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_frame", bus.frame, 0);
    chk("rst_in_1", bus.in_1, 0);
    chk("rst_in_2", bus.in_2, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.sample_drop, 0);

    for (int k = 0; k < T; k++) begin
      bus.w_we = 1'b1; bus.w_addr = 7'(k); bus.w_data = 24'(k + 1);
      tick();
    end
    bus.w_addr = 7'd127; bus.w_data = 24'h123456;
    tick();
    bus.w_we = 1'b0;

    // Single sample run and accumulated inner product.
    acc = 0;
    pulse(16'sd100);
    chk("s1_frame1", bus.frame, 1);
    chk("s1_in1_f1", bus.in_1, 100);
    chk("s1_in2_f1", bus.in_2, 1);
    acc += longint'(bus.in_1) * longint'(bus.in_2);
    for (int f = 2; f <= T; f++) begin
      tick();
      acc += longint'(bus.in_1) * longint'(bus.in_2);
      if (f == 2) begin
        chk("s1_in1_f2", bus.in_1, 0);
        chk("s1_in2_f2", bus.in_2, 2);
      end
    end
    chk("s1_frame126", bus.frame, 126);
    chk("s1_in2_f126", bus.in_2, 126);
    tick();
    chk("s1_frame127", bus.frame, 127);
    chk("s1_busy127", bus.busy, 1);
    chk("s1_acc", acc, 100);
    tick();
    chk("s1_frame_end", bus.frame, 0);
    chk("s1_busy_end", bus.busy, 0);

    // Ordering and pointer wrap, minimum spacing of T+2 cycles.
    for (int s = 1; s <= 130; s++) begin
      pulse(16'(s));
      if (s == 130) chk("wrap_in1_f1", bus.in_1, 130);
      repeat (125) tick();
      if (s == 130) begin
        chk("wrap_frame126", bus.frame, 126);
        chk("wrap_in1_f126", bus.in_1, 5);
      end
      repeat (2) tick();
    end

    // Collisions during RUN and on the DONE cycle.
    pulse(16'sd300);
    repeat (49) tick();
    chk("col_frame50", bus.frame, 50);
    bus.sample_valid = 1'b1; bus.sample_in = -16'sd7;
    tick();
    bus.sample_valid = 1'b0;
    chk("col_drop", bus.sample_drop, 1);
    tick();
    chk("col_drop_clear", bus.sample_drop, 0);
    repeat (75) tick();
    chk("col_frame127", bus.frame, 127);
    bus.sample_valid = 1'b1; bus.sample_in = -16'sd9;
    tick();
    bus.sample_valid = 1'b0;
    chk("col_done_drop", bus.sample_drop, 1);
    chk("col_done_frame", bus.frame, 0);
    pulse(16'sd200);
    chk("col_in1_f1", bus.in_1, 200);
    tick();
    chk("col_in1_f2", bus.in_1, 300);

    // Weight write race and out-of-range write.
    repeat (8) tick();
    chk("wr_frame10", bus.frame, 10);
    chk("wr_old_in2", bus.in_2, 10);
    bus.w_we = 1'b1; bus.w_addr = 7'd9; bus.w_data = 24'sh7FFFFF;
    tick();
    chk("wr_in2_f11", bus.in_2, 11);
    bus.w_addr = 7'd127; bus.w_data = '0;
    tick();
    bus.w_we = 1'b0;
    repeat (116) tick();
    chk("wr_idle", bus.frame, 0);
    pulse(16'sd400);
    repeat (9) tick();
    chk("wr_new_in2", bus.in_2, 24'sh7FFFFF);
    chk("wr_in1_f10", bus.in_1, 124);
    repeat (118) tick();

    // Asynchronous reset mid-run.
    pulse(16'sd55);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_frame", bus.frame, 0);
    chk("mrst_in1", bus.in_1, 0);
    chk("mrst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulse(16'sd77);
    chk("mrst_in1_f1", bus.in_1, 77);
    chk("mrst_in2_f1", bus.in_2, 0);
    tick();
    chk("mrst_in1_f2", bus.in_1, 0);
    repeat (126) tick();

`ifdef ANC_TAP_SEQ_FLUSH_EN
    bus.w_we = 1'b1; bus.w_addr = 7'd0; bus.w_data = 24'sd42;
    tick();
    bus.w_we = 1'b0;
    pulse(16'sd33);
    repeat (59) tick();
    chk("fl_frame60", bus.frame, 60);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_frame", bus.frame, 0);
    chk("fl_busy", bus.busy, 0);
    flush = 1'b1; bus.sample_valid = 1'b1; bus.sample_in = 16'sd99;
    tick();
    flush = 1'b0; bus.sample_valid = 1'b0;
    chk("fl_sv_frame", bus.frame, 0);
    chk("fl_sv_drop", bus.sample_drop, 0);
    pulse(16'sd5);
    chk("fl_in1_f1", bus.in_1, 5);
    chk("fl_in2_f1", bus.in_2, 42);
    zero_ok = 1'b1;
    for (int f = 2; f <= T; f++) begin
      tick();
      if (bus.in_1 !== 16'sd0) zero_ok = 1'b0;
    end
    chk("fl_in1_zero", zero_ok, 1);
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
